control_unit: RTL
=================

Name: control_unit

Overview:
Multicycle FSM driving the `cpu` datapath: consumes the instruction fields and ALU flags, produces every datapath control signal. Supported subset: add/sub/and/slt/jr, addi, beq/bne, lw/sw, j/jal, plus invalid-opcode and overflow exceptions through EPC.

Parameters:
MEM_WAIT, 2, cycles from address-valid to Memoria data-valid (>=1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
OPCODE  in  6  IR[31:26]
funct  in  6  IR[5:0]
Overflow, zero  in  1 each  ula32 flags (combinational, current cycle)
PC_write, MEMRead(1=write), IRWrite, MDR_load, RegWrite, A_load, B_load, AluOutWrite, EPCWrite  out  1 each  load/write enables
ALU_control  out  3  001 add, 010 sub, 011 and, 111 compare, 000 pass A
IorD  out  3  0 PC, 3 ALUOut, 4 addr 253, 5 addr 254
RegDst  out  2  0 rt, 1 rd, 2 $31
MenToReg  out  3  0 ALUOut, 3 SE1_32, 5 LS_out
ALUSourceA  out  2  0 PC, 1 A
ALUSourceB  out  3  0 B, 1 const 4, 2 SE16, 3 SL2
PCSource  out  3  0 ALU_result, 1 ALUOut, 2 EPC, 3 jump concat, 4 LS_out, 5 A
store_control_sign, load_size_control  out  2 each  0 word, 2 byte
state_out  out  5  current state (debug/verification)

Behaviour:
- Every output not listed for a state is 0. Outputs decode from state, wait counter and flags; Overflow and zero are Mealy inputs.
- reset asserted at any time: state=RESET, counter=0, all outputs 0 in the same cycle. RESET lasts 1 cycle, then FETCH.
- FETCH (MEM_WAIT cycles): IorD=0, SrcA=0, SrcB=1, ALU=001. On the last cycle, also IRWrite=1, PC_write=1, PCSource=0. Then DECODE.
- DECODE (1 cycle): A_load, B_load, SrcA=0, SrcB=3, ALU=001, AluOutWrite (branch target). Then dispatch on OPCODE/funct:
  - 0x00/0x20,0x22,0x24 -> EXEC_R
  - 0x00/0x2A -> SLT
  - 0x00/0x08 -> JR
  - 0x08 -> ADDI
  - 0x04/0x05 -> BRANCH
  - 0x23/0x2B -> ADDR
  - 0x02 -> J
  - 0x03 -> JAL_LINK
  - anything else -> EXC_SAVE with cause=opcode.
- EXEC_R: SrcA=1, SrcB=0, ALU per funct, AluOutWrite. If Overflow and funct is add/sub -> EXC_SAVE (cause=ovf); otherwise -> WB_R. and never faults.
- WB_R: RegDst=1, MenToReg=0, RegWrite -> FETCH.
- SLT: SrcA=1, SrcB=0, ALU=111, RegDst=1, MenToReg=3, RegWrite -> FETCH.
- JR: PCSource=5, PC_write -> FETCH.
- ADDI: SrcA=1, SrcB=2, ALU=001, AluOutWrite. Overflow -> EXC_SAVE (ovf); otherwise -> WB_I.
- WB_I: RegDst=0, MenToReg=0, RegWrite -> FETCH.
- BRANCH: SrcA=1, SrcB=0, ALU=010, PCSource=1. PC_write=zero for beq, !zero for bne -> FETCH.
- ADDR: SrcA=1, SrcB=2, ALU=001, AluOutWrite; Overflow ignored. lw -> MEM_RD, sw -> MEM_WR.
- MEM_RD (MEM_WAIT cycles): IorD=3; MDR_load on the last cycle -> LW_WB.
- LW_WB: RegDst=0, MenToReg=5, load_size=0, RegWrite -> FETCH.
- MEM_WR (1 cycle): IorD=3, MEMRead=1, store_control_sign=0 -> FETCH.
- J: PCSource=3, PC_write -> FETCH.
- JAL_LINK: SrcA=0, ALU=000, AluOutWrite -> JAL_WB.
- JAL_WB: RegDst=2, MenToReg=0, RegWrite, PCSource=3, PC_write -> FETCH.
- EXC_SAVE: SrcA=0, SrcB=1, ALU=010 (PC-4), AluOutWrite -> EXC_EPC.
- EXC_EPC (MEM_WAIT cycles): EPCWrite on the first cycle only. IorD=4 for opcode cause, 5 for ovf -> EXC_JUMP.
- EXC_JUMP: load_size=2, PCSource=4, PC_write -> FETCH.
- Cause is a 1-bit register written only on entry to EXC_SAVE; reset value 0.
- Wait counter: counts 0..MEM_WAIT-1 inside FETCH/MEM_RD/EXC_EPC, cleared on every state change. With MEM_WAIT=1, the wait states last one cycle.
- RegWrite and MEMRead are never 1 in the same cycle.
- PC_write is never asserted in a faulting EXEC_R/ADDI cycle.

Decomposition:
- Package ctrl_pkg holds: opcode/funct constants, state encoding (5-bit), ALU op codes, and the select codes for every mux listed above.
- One sub-module is natural: ctrl_wait_counter (load/clear/done, width $clog2(MEM_WAIT+1)).
- Everything else stays in control_unit.

Test Plan:
- Reset: assert reset mid-FETCH -> all outputs 0 immediately, state_out=RESET. Deassert -> 1 cycle RESET, then FETCH with IorD=0, ALU=001.
- add (op 0x00, funct 0x20), Overflow=0, MEM_WAIT=2 -> IRWrite/PC_write on FETCH cycle 2; EXEC_R ALU=001; WB_R RegDst=1, RegWrite=1; back in FETCH after 5 cycles.
- beq, zero=1 -> BRANCH PC_write=1, PCSource=1. bne, zero=1 -> PC_write=0. Both return to FETCH.
- lw -> MEM_RD 2 cycles with IorD=3, MDR_load on cycle 2 only; LW_WB MenToReg=5, RegWrite=1. sw -> MEMRead=1 for exactly 1 cycle with IorD=3.
- addi with Overflow=1 in ADDI -> no RegWrite; EXC_SAVE ALU=010; EPCWrite for 1 cycle; IorD=5; EXC_JUMP PCSource=4, load_size=2, PC_write=1.
- OPCODE 0x3F, and separately R-type funct 0x3F -> EXC path with IorD=4. jal -> JAL_WB RegDst=2, PCSource=3, RegWrite=1, PC_write=1 in the same cycle.

Source files
------------

// File: rtl/control_unit_pkg.sv
// Shared constants for the multicycle control unit: opcodes, functs, state codes,
// ALU operations and datapath mux select codes.
package ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   localparam logic [4:0] S_RESET    = 5'd0;
   localparam logic [4:0] S_FETCH    = 5'd1;
   localparam logic [4:0] S_DECODE   = 5'd2;
   localparam logic [4:0] S_EXEC_R   = 5'd3;
   localparam logic [4:0] S_WB_R     = 5'd4;
   localparam logic [4:0] S_SLT      = 5'd5;
   localparam logic [4:0] S_JR       = 5'd6;
   localparam logic [4:0] S_ADDI     = 5'd7;
   localparam logic [4:0] S_WB_I     = 5'd8;
   localparam logic [4:0] S_BRANCH   = 5'd9;
   localparam logic [4:0] S_ADDR     = 5'd10;
   localparam logic [4:0] S_MEM_RD   = 5'd11;
   localparam logic [4:0] S_LW_WB    = 5'd12;
   localparam logic [4:0] S_MEM_WR   = 5'd13;
   localparam logic [4:0] S_J        = 5'd14;
   localparam logic [4:0] S_JAL_LINK = 5'd15;
   localparam logic [4:0] S_JAL_WB   = 5'd16;
   localparam logic [4:0] S_EXC_SAVE = 5'd17;
   localparam logic [4:0] S_EXC_EPC  = 5'd18;
   localparam logic [4:0] S_EXC_JUMP = 5'd19;

   localparam logic [2:0] ALU_PASS_A = 3'b000;
   localparam logic [2:0] ALU_ADD    = 3'b001;
   localparam logic [2:0] ALU_SUB    = 3'b010;
   localparam logic [2:0] ALU_AND    = 3'b011;
   localparam logic [2:0] ALU_CMP    = 3'b111;

   localparam logic [2:0] IORD_PC     = 3'd0;
   localparam logic [2:0] IORD_ALUOUT = 3'd3;
   localparam logic [2:0] IORD_253    = 3'd4;
   localparam logic [2:0] IORD_254    = 3'd5;

   localparam logic [1:0] RD_RT = 2'd0;
   localparam logic [1:0] RD_RD = 2'd1;
   localparam logic [1:0] RD_31 = 2'd2;

   localparam logic [2:0] M2R_ALUOUT = 3'd0;
   localparam logic [2:0] M2R_SE1    = 3'd3;
   localparam logic [2:0] M2R_LS     = 3'd5;

   localparam logic [1:0] SRCA_PC = 2'd0;
   localparam logic [1:0] SRCA_A  = 2'd1;

   localparam logic [2:0] SRCB_B    = 3'd0;
   localparam logic [2:0] SRCB_4    = 3'd1;
   localparam logic [2:0] SRCB_SE16 = 3'd2;
   localparam logic [2:0] SRCB_SL2  = 3'd3;

   localparam logic [2:0] PCS_ALU    = 3'd0;
   localparam logic [2:0] PCS_ALUOUT = 3'd1;
   localparam logic [2:0] PCS_EPC    = 3'd2;
   localparam logic [2:0] PCS_JUMP   = 3'd3;
   localparam logic [2:0] PCS_LS     = 3'd4;
   localparam logic [2:0] PCS_A      = 3'd5;

   localparam logic [1:0] SIZE_WORD = 2'd0;
   localparam logic [1:0] SIZE_BYTE = 2'd2;

   typedef enum logic {
      CAUSE_OPCODE = 1'b0,
      CAUSE_OVF    = 1'b1
   } cause_e;

   function automatic logic is_wait_state(input logic [4:0] s);
      return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_EXC_EPC);
   endfunction

endpackage

// File: rtl/control_unit_if.sv
// Bundle between the control unit and the datapath: instruction fields and ALU
// flags in, every datapath control signal out.
interface control_unit_if;
   logic [5:0] OPCODE;
   logic [5:0] funct;
   logic       Overflow;
   logic       zero;

   logic       PC_write, MEMRead, IRWrite, MDR_load, RegWrite;
   logic       A_load, B_load, AluOutWrite, EPCWrite;
   logic [2:0] ALU_control;
   logic [2:0] IorD;
   logic [1:0] RegDst;
   logic [2:0] MenToReg;
   logic [1:0] ALUSourceA;
   logic [2:0] ALUSourceB;
   logic [2:0] PCSource;
   logic [1:0] store_control_sign;
   logic [1:0] load_size_control;
   logic [4:0] state_out;

   modport master (
      input  OPCODE, funct, Overflow, zero,
      output PC_write, MEMRead, IRWrite, MDR_load, RegWrite, A_load, B_load,
             AluOutWrite, EPCWrite, ALU_control, IorD, RegDst, MenToReg,
             ALUSourceA, ALUSourceB, PCSource, store_control_sign,
             load_size_control, state_out
   );

   modport slave (
      output OPCODE, funct, Overflow, zero,
      input  PC_write, MEMRead, IRWrite, MDR_load, RegWrite, A_load, B_load,
             AluOutWrite, EPCWrite, ALU_control, IorD, RegDst, MenToReg,
             ALUSourceA, ALUSourceB, PCSource, store_control_sign,
             load_size_control, state_out
   );
endinterface

// File: rtl/control_unit_wait_counter.sv
// Cycle counter for the memory-wait states; done flags the final wait cycle.
module ctrl_wait_counter #(
   parameter int MEM_WAIT = 2,
   parameter int CW       = $clog2(MEM_WAIT + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear_i,
   input  logic          inc_i,
   output logic [CW-1:0] count_o,
   output logic          done_o
);
   logic [CW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i)
         count_d = '0;
      else if (inc_i)
         count_d = count_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   assign count_o = count_q;
   assign done_o  = (count_q == CW'(MEM_WAIT - 1));
endmodule

// File: rtl/control_unit.sv
// Multicycle control FSM for the cpu datapath; outputs decode from state, wait
// count and the live ALU flags.
module control_unit
   import ctrl_pkg::*;
#(
   parameter int MEM_WAIT = 2
) (
   input logic           clk,
   input logic           reset,
   control_unit_if.master bus
);
   localparam int CW = $clog2(MEM_WAIT + 1);

   logic [4:0]    state_q, state_d;
   cause_e        cause_q, cause_d;
   logic [CW-1:0] wait_cnt;
   logic          wait_done, wait_clear, wait_inc;
   logic          r_arith;

   assign r_arith    = (bus.funct == FN_ADD) || (bus.funct == FN_SUB);
   assign wait_clear = (state_d != state_q);
   assign wait_inc   = !wait_clear && is_wait_state(state_q);

   ctrl_wait_counter #(.MEM_WAIT(MEM_WAIT), .CW(CW)) u_wait (
      .clk     (clk),
      .rst     (reset),
      .clear_i (wait_clear),
      .inc_i   (wait_inc),
      .count_o (wait_cnt),
      .done_o  (wait_done)
   );

   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      case (state_q)
         S_RESET:  state_d = S_FETCH;
         S_FETCH:  if (wait_done) state_d = S_DECODE;
         S_DECODE: begin
            case (bus.OPCODE)
               OP_RTYPE: begin
                  case (bus.funct)
                     FN_ADD, FN_SUB, FN_AND: state_d = S_EXEC_R;
                     FN_SLT:                 state_d = S_SLT;
                     FN_JR:                  state_d = S_JR;
                     default: begin
                        state_d = S_EXC_SAVE;
                        cause_d = CAUSE_OPCODE;
                     end
                  endcase
               end
               OP_ADDI:        state_d = S_ADDI;
               OP_BEQ, OP_BNE: state_d = S_BRANCH;
               OP_LW, OP_SW:   state_d = S_ADDR;
               OP_J:           state_d = S_J;
               OP_JAL:         state_d = S_JAL_LINK;
               default: begin
                  state_d = S_EXC_SAVE;
                  cause_d = CAUSE_OPCODE;
               end
            endcase
         end
         S_EXEC_R: begin
            if (bus.Overflow && r_arith) begin
               state_d = S_EXC_SAVE;
               cause_d = CAUSE_OVF;
            end else begin
               state_d = S_WB_R;
            end
         end
         S_ADDI: begin
            if (bus.Overflow) begin
               state_d = S_EXC_SAVE;
               cause_d = CAUSE_OVF;
            end else begin
               state_d = S_WB_I;
            end
         end
         S_ADDR:     state_d = (bus.OPCODE == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:   if (wait_done) state_d = S_LW_WB;
         S_JAL_LINK: state_d = S_JAL_WB;
         S_EXC_SAVE: state_d = S_EXC_EPC;
         S_EXC_EPC:  if (wait_done) state_d = S_EXC_JUMP;
         default:    state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_RESET;
         cause_q <= CAUSE_OPCODE;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
      end
   end

   always_comb begin
      bus.PC_write           = 1'b0;
      bus.MEMRead            = 1'b0;
      bus.IRWrite            = 1'b0;
      bus.MDR_load           = 1'b0;
      bus.RegWrite           = 1'b0;
      bus.A_load             = 1'b0;
      bus.B_load             = 1'b0;
      bus.AluOutWrite        = 1'b0;
      bus.EPCWrite           = 1'b0;
      bus.ALU_control        = ALU_PASS_A;
      bus.IorD               = IORD_PC;
      bus.RegDst             = RD_RT;
      bus.MenToReg           = M2R_ALUOUT;
      bus.ALUSourceA         = SRCA_PC;
      bus.ALUSourceB         = SRCB_B;
      bus.PCSource           = PCS_ALU;
      bus.store_control_sign = SIZE_WORD;
      bus.load_size_control  = SIZE_WORD;
      case (state_q)
         S_FETCH: begin
            bus.ALUSourceB  = SRCB_4;
            bus.ALU_control = ALU_ADD;
            bus.IRWrite     = wait_done;
            bus.PC_write    = wait_done;
         end
         S_DECODE: begin
            bus.A_load      = 1'b1;
            bus.B_load      = 1'b1;
            bus.ALUSourceB  = SRCB_SL2;
            bus.ALU_control = ALU_ADD;
            bus.AluOutWrite = 1'b1;
         end
         S_EXEC_R: begin
            bus.ALUSourceA  = SRCA_A;
            bus.AluOutWrite = 1'b1;
            case (bus.funct)
               FN_SUB:  bus.ALU_control = ALU_SUB;
               FN_AND:  bus.ALU_control = ALU_AND;
               default: bus.ALU_control = ALU_ADD;
            endcase
         end
         S_WB_R: begin
            bus.RegDst   = RD_RD;
            bus.RegWrite = 1'b1;
         end
         S_SLT: begin
            bus.ALUSourceA  = SRCA_A;
            bus.ALU_control = ALU_CMP;
            bus.RegDst      = RD_RD;
            bus.MenToReg    = M2R_SE1;
            bus.RegWrite    = 1'b1;
         end
         S_JR: begin
            bus.PCSource = PCS_A;
            bus.PC_write = 1'b1;
         end
         S_ADDI, S_ADDR: begin
            bus.ALUSourceA  = SRCA_A;
            bus.ALUSourceB  = SRCB_SE16;
            bus.ALU_control = ALU_ADD;
            bus.AluOutWrite = 1'b1;
         end
         S_WB_I: bus.RegWrite = 1'b1;
         S_BRANCH: begin
            bus.ALUSourceA  = SRCA_A;
            bus.ALU_control = ALU_SUB;
            bus.PCSource    = PCS_ALUOUT;
            bus.PC_write    = (bus.OPCODE == OP_BEQ) ? bus.zero : !bus.zero;
         end
         S_MEM_RD: begin
            bus.IorD     = IORD_ALUOUT;
            bus.MDR_load = wait_done;
         end
         S_LW_WB: begin
            bus.MenToReg = M2R_LS;
            bus.RegWrite = 1'b1;
         end
         S_MEM_WR: begin
            bus.IorD    = IORD_ALUOUT;
            bus.MEMRead = 1'b1;
         end
         S_J: begin
            bus.PCSource = PCS_JUMP;
            bus.PC_write = 1'b1;
         end
         S_JAL_LINK: bus.AluOutWrite = 1'b1;
         S_JAL_WB: begin
            bus.RegDst   = RD_31;
            bus.RegWrite = 1'b1;
            bus.PCSource = PCS_JUMP;
            bus.PC_write = 1'b1;
         end
         S_EXC_SAVE: begin
            bus.ALUSourceB  = SRCB_4;
            bus.ALU_control = ALU_SUB;
            bus.AluOutWrite = 1'b1;
         end
         S_EXC_EPC: begin
            bus.EPCWrite = (wait_cnt == '0);
            bus.IorD     = (cause_q == CAUSE_OVF) ? IORD_254 : IORD_253;
         end
         S_EXC_JUMP: begin
            bus.load_size_control = SIZE_BYTE;
            bus.PCSource          = PCS_LS;
            bus.PC_write          = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.state_out = state_q;
endmodule
